// File: rtl/gem_cluster_pkg.sv
// rtl/gem_cluster_pkg.sv - shared widths, empty-slot address and merge FSM encoding
package gem_cluster_pkg;

    localparam int MXADRBITS   = 11;
    localparam int MXCNTBITS   = 3;
    localparam int INVALID_ADR = 2046;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MERGE   = 2'd1,
        PUBLISH = 2'd2
    } merge_state_t;

endpackage

// File: rtl/cluster_seg_bank.sv
// rtl/cluster_seg_bank.sv - ping-pong per-segment frame buffer with compacting write pointer
module cluster_seg_bank
    import gem_cluster_pkg::*;
#(
    parameter int NPERSEG = 8,
    parameter int ADR_W   = MXADRBITS,
    parameter int CNT_W   = MXCNTBITS,
    parameter int PW      = $clog2(NPERSEG + 1)
) (
    input  logic                     clock4x,
    input  logic                     global_reset,
    input  logic                     frame_start,
    input  logic                     slot_active,
    input  logic                     swap,
    input  logic                     vpf,
    input  logic [ADR_W-1:0]         adr,
    input  logic [CNT_W-1:0]         cnt,
    output logic [NPERSEG*ADR_W-1:0] rd_adr,
    output logic [NPERSEG*CNT_W-1:0] rd_cnt,
    output logic [PW-1:0]            rd_n
);

    localparam int IW = $clog2(NPERSEG);

    logic             wr_bank;
    logic [PW-1:0]    n_q [2];
    logic [ADR_W-1:0] adr_mem [2][NPERSEG];
    logic [CNT_W-1:0] cnt_mem [2][NPERSEG];
    logic [PW-1:0]    wptr;
    logic             wr_en;

    // A new frame (including a restart after abort) always writes from entry 0.
    assign wptr  = frame_start ? '0 : n_q[wr_bank];
    assign wr_en = (frame_start | slot_active) & vpf;

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            wr_bank <= 1'b0;
            n_q[0]  <= '0;
            n_q[1]  <= '0;
        end else begin
            if (wr_en)
                n_q[wr_bank] <= wptr + PW'(1);
            else if (frame_start)
                n_q[wr_bank] <= '0;
            if (swap)
                wr_bank <= ~wr_bank;
        end
    end

    always_ff @(posedge clock4x) begin
        if (wr_en) begin
            adr_mem[wr_bank][wptr[IW-1:0]] <= adr;
            cnt_mem[wr_bank][wptr[IW-1:0]] <= cnt;
        end
    end

    for (genvar j = 0; j < NPERSEG; j++) begin : g_rd
        assign rd_adr[j*ADR_W +: ADR_W] = adr_mem[~wr_bank][j];
        assign rd_cnt[j*CNT_W +: CNT_W] = cnt_mem[~wr_bank][j];
    end
    assign rd_n = n_q[~wr_bank];

endmodule

// File: rtl/cluster_merge_nofm.sv
// rtl/cluster_merge_nofm.sv - frame collector and cross-segment cluster merger
module cluster_merge_nofm
    import gem_cluster_pkg::*;
#(
    parameter int NSEG        = 2,
    parameter int SEG_WIDTH   = 768,
    parameter int NPERSEG     = 8,
    parameter int NOUT        = 8,
    parameter int MXADRBITS   = gem_cluster_pkg::MXADRBITS,
    parameter int MXCNTBITS   = gem_cluster_pkg::MXCNTBITS,
    parameter int INVALID_ADR = gem_cluster_pkg::INVALID_ADR
) (
    input  logic                                clock4x,
    input  logic                                global_reset,
    input  logic                                frame_start,
    input  logic [NSEG-1:0]                     seg_vpf,
    input  logic [NSEG*MXADRBITS-1:0]           seg_adr,
    input  logic [NSEG*MXCNTBITS-1:0]           seg_cnt,
    output logic [NOUT-1:0]                     out_vld,
    output logic [NOUT*MXADRBITS-1:0]           out_adr,
    output logic [NOUT*MXCNTBITS-1:0]           out_cnt,
    output logic                                result_valid,
    output logic [$clog2(NSEG*NPERSEG+1)-1:0]   nclusters,
    output logic                                overflow,
    output logic                                frame_abort
);

    localparam int NCW = $clog2(NSEG*NPERSEG + 1);
    localparam int PW  = $clog2(NPERSEG + 1);
    localparam int SLW = $clog2(NPERSEG);
    localparam int SW  = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [MXADRBITS-1:0] INV = MXADRBITS'(INVALID_ADR);

    if (NSEG < 1 || NSEG > NPERSEG - 1) begin : g_bad_nseg
        $error("cluster_merge_nofm: NSEG must satisfy 1 <= NSEG <= NPERSEG-1");
    end
    if (NOUT < 1 || NOUT > NSEG*NPERSEG) begin : g_bad_nout
        $error("cluster_merge_nofm: NOUT must satisfy 1 <= NOUT <= NSEG*NPERSEG");
    end
    if (NSEG*SEG_WIDTH > 2**MXADRBITS - 2) begin : g_bad_adr
        $error("cluster_merge_nofm: NSEG*SEG_WIDTH exceeds address range");
    end

    // Slot counter
    logic           active;
    logic [SLW-1:0] slot;
    logic           last;

    assign last = active & ~frame_start & (slot == SLW'(NPERSEG - 1));

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            active      <= 1'b0;
            slot        <= '0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= frame_start & active;
            if (frame_start) begin
                active <= 1'b1;
                slot   <= SLW'(1);
            end else if (active) begin
                if (last)
                    active <= 1'b0;
                else
                    slot <= slot + SLW'(1);
            end
        end
    end

    logic [NPERSEG*MXADRBITS-1:0] bank_adr [NSEG];
    logic [NPERSEG*MXCNTBITS-1:0] bank_cnt [NSEG];
    logic [PW-1:0]                bank_n   [NSEG];

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
        cluster_seg_bank #(
            .NPERSEG (NPERSEG),
            .ADR_W   (MXADRBITS),
            .CNT_W   (MXCNTBITS),
            .PW      (PW)
        ) u_bank (
            .clock4x      (clock4x),
            .global_reset (global_reset),
            .frame_start  (frame_start),
            .slot_active  (active),
            .swap         (last),
            .vpf          (seg_vpf[s]),
            .adr          (seg_adr[s*MXADRBITS +: MXADRBITS]),
            .cnt          (seg_cnt[s*MXCNTBITS +: MXCNTBITS]),
            .rd_adr       (bank_adr[s]),
            .rd_cnt       (bank_cnt[s]),
            .rd_n         (bank_n[s])
        );
    end

    // Merge FSM
    merge_state_t state_q, state_d;
    logic         acc_clear, do_merge, do_publish;
    logic [SW-1:0] seg_q;

    always_comb begin
        state_d    = state_q;
        acc_clear  = 1'b0;
        do_merge   = 1'b0;
        do_publish = 1'b0;
        case (state_q)
            IDLE: begin
                if (last) begin
                    acc_clear = 1'b1;
                    state_d   = MERGE;
                end
            end
            MERGE: begin
                do_merge = 1'b1;
                if (seg_q == SW'(NSEG - 1))
                    state_d = PUBLISH;
            end
            PUBLISH: begin
                do_publish = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [MXADRBITS-1:0] acc_adr [NOUT];
    logic [MXCNTBITS-1:0] acc_cnt [NOUT];
    logic [MXADRBITS-1:0] m_adr   [NOUT];
    logic [MXCNTBITS-1:0] m_cnt   [NOUT];
    logic [NCW-1:0]       fill_q;
    logic [PW-1:0]        cur_n;
    logic [MXADRBITS-1:0] seg_off;

    // Current segment's entries land at fill_q..fill_q+n-1; anything past NOUT is dropped.
    always_comb begin
        m_adr   = acc_adr;
        m_cnt   = acc_cnt;
        cur_n   = bank_n[seg_q];
        seg_off = MXADRBITS'(int'(seg_q) * SEG_WIDTH);
        for (int i = 0; i < NOUT; i++) begin
            if (i >= int'(fill_q) && i < int'(fill_q) + int'(cur_n)) begin
                m_adr[i] = bank_adr[seg_q][(i - int'(fill_q))*MXADRBITS +: MXADRBITS] + seg_off;
                m_cnt[i] = bank_cnt[seg_q][(i - int'(fill_q))*MXCNTBITS +: MXCNTBITS];
            end
        end
    end

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            state_q      <= IDLE;
            seg_q        <= '0;
            fill_q       <= '0;
            result_valid <= 1'b0;
            out_vld      <= '0;
            out_adr      <= {NOUT{INV}};
            out_cnt      <= '0;
            nclusters    <= '0;
            overflow     <= 1'b0;
            for (int i = 0; i < NOUT; i++) begin
                acc_adr[i] <= INV;
                acc_cnt[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            result_valid <= do_publish;
            if (acc_clear) begin
                seg_q  <= '0;
                fill_q <= '0;
                for (int i = 0; i < NOUT; i++) begin
                    acc_adr[i] <= INV;
                    acc_cnt[i] <= '0;
                end
            end else if (do_merge) begin
                seg_q   <= seg_q + SW'(1);
                fill_q  <= fill_q + NCW'(cur_n);
                acc_adr <= m_adr;
                acc_cnt <= m_cnt;
            end
            if (do_publish) begin
                for (int i = 0; i < NOUT; i++) begin
                    out_vld[i]                        <= (i < int'(fill_q));
                    out_adr[i*MXADRBITS +: MXADRBITS] <= acc_adr[i];
                    out_cnt[i*MXCNTBITS +: MXCNTBITS] <= acc_cnt[i];
                end
                nclusters <= fill_q;
                overflow  <= (int'(fill_q) > NOUT);
            end
        end
    end

endmodule
